fft8_frame_ctrl: RTL and testbench

//  Frame sequencer for the 3-stage 8-point radix-2 FFT datapath (fft_stage1..3).
//  - Accepts a serial real-sample stream (valid/ready).
//  - Packs 8 samples into a frame buffer in bit-reversed slot order and holds it stable on the datapath input bus.
//  - Times the pipeline latency, captures the 8 complex results, then streams them out in natural order with backpressure.

---
 rtl/fft8_frame_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_fft8_frame_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_frame_ctrl.sv
// fft8_frame_ctrl
// Frame sequencer for the 3-stage 8-point radix-2 FFT datapath.
// It collects eight real samples from a valid/ready stream and places them in
// the frame buffer in bit-reversed slot order. The frame buffer drives the
// datapath input bus. The block then waits out the pipeline latency, captures
// the eight complex results, and streams them out in natural bin order with
// backpressure.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous reset, active low
//   in_valid    input sample valid
//   in_ready    block can accept a sample (FILL only)
//   in_data     real input sample, W bits
//   fft_x       datapath input bus, slot s at [s*W +: W]
//   fft_launch  one-cycle pulse in the first WAIT cycle
//   fft_yr      datapath real results, bin k at [k*W +: W]
//   fft_yi      datapath imaginary results, same layout
//   out_valid   output bin valid (DRAIN only)
//   out_ready   downstream accepts the current bin
//   out_re      real part of the current bin
//   out_im      imaginary part of the current bin
//   out_idx     current bin index 0..7
//   out_last    high with bin 7
//   busy        high in WAIT or DRAIN
//   frame_cnt   completed frames, wraps 255 -> 0
module fft8_frame_ctrl #(
   parameter int W        = 16,
   parameter int PIPE_LAT = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_data,
   output logic [8*W-1:0] fft_x,
   output logic           fft_launch,
   input  logic [8*W-1:0] fft_yr,
   input  logic [8*W-1:0] fft_yi,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_re,
   output logic [W-1:0]   out_im,
   output logic [2:0]     out_idx,
   output logic           out_last,
   output logic           busy,
   output logic [7:0]     frame_cnt
);

   localparam int WCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(PIPE_LAT - 1);

   typedef enum logic [1:0] {S_FILL, S_WAIT, S_DRAIN} state_t;

   state_t         state_q, state_d;
   logic [2:0]     wr_cnt_q, wr_cnt_d;
   logic [2:0]     rd_cnt_q, rd_cnt_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic [7:0]     frame_cnt_q, frame_cnt_d;
   logic           in_ready_q, in_ready_d;
   logic           out_valid_q, out_valid_d;
   logic           busy_q, busy_d;
   logic           fft_launch_q, fft_launch_d;
   logic [W-1:0]   frame_q [8];
   logic [W-1:0]   frame_d [8];
   logic [W-1:0]   res_re_q [8];
   logic [W-1:0]   res_re_d [8];
   logic [W-1:0]   res_im_q [8];
   logic [W-1:0]   res_im_d [8];

   function automatic logic [2:0] bitrev3(input logic [2:0] k);
      return {k[0], k[1], k[2]};
   endfunction

   // Next-state logic for the FILL -> WAIT -> DRAIN sequence.
   // The handshake outputs are derived from the next state so that they are
   // registered and line up with the state they belong to. For example,
   // in_ready stays low during the cycle in which bin 7 is accepted and
   // rises one cycle later.
   always_comb begin
      state_d     = state_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      frame_cnt_d = frame_cnt_q;
      frame_d     = frame_q;
      res_re_d    = res_re_q;
      res_im_d    = res_im_q;
      case (state_q)
         S_FILL: begin
            if (in_valid && in_ready_q) begin
               frame_d[bitrev3(wr_cnt_q)] = in_data;
               // wr_cnt wraps back to 0 when the eighth sample is accepted.
               wr_cnt_d = wr_cnt_q + 3'd1;
               if (wr_cnt_q == 3'd7) begin
                  state_d    = S_WAIT;
                  wait_cnt_d = '0;
               end
            end
         end
         S_WAIT: begin
            if (wait_cnt_q == WAIT_LAST) begin
               for (int k = 0; k < 8; k++) begin
                  res_re_d[k] = fft_yr[k*W +: W];
                  res_im_d[k] = fft_yi[k*W +: W];
               end
               state_d    = S_DRAIN;
               wait_cnt_d = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            // out_valid is always high in DRAIN, so out_ready alone completes
            // the handshake.
            if (out_ready) begin
               rd_cnt_d = rd_cnt_q + 3'd1;
               if (rd_cnt_q == 3'd7) begin
                  state_d     = S_FILL;
                  frame_cnt_d = frame_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = S_FILL;
      endcase
      in_ready_d   = (state_d == S_FILL);
      out_valid_d  = (state_d == S_DRAIN);
      busy_d       = (state_d != S_FILL);
      fft_launch_d = (state_q == S_FILL) && (state_d == S_WAIT);
   end

   // State and buffer registers.
   // Reset aborts any frame that is in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_FILL;
         wr_cnt_q     <= '0;
         rd_cnt_q     <= '0;
         wait_cnt_q   <= '0;
         frame_cnt_q  <= '0;
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         fft_launch_q <= 1'b0;
         for (int k = 0; k < 8; k++) begin
            frame_q[k]  <= '0;
            res_re_q[k] <= '0;
            res_im_q[k] <= '0;
         end
      end else begin
         state_q      <= state_d;
         wr_cnt_q     <= wr_cnt_d;
         rd_cnt_q     <= rd_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         frame_cnt_q  <= frame_cnt_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         busy_q       <= busy_d;
         fft_launch_q <= fft_launch_d;
         frame_q      <= frame_d;
         res_re_q     <= res_re_d;
         res_im_q     <= res_im_d;
      end
   end

   // The frame buffer is always visible on the bus.
   // This includes a partial frame while FILL is still collecting samples.
   for (genvar s = 0; s < 8; s++) begin : g_fft_x
      assign fft_x[s*W +: W] = frame_q[s];
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign busy       = busy_q;
   assign fft_launch = fft_launch_q;
   assign frame_cnt  = frame_cnt_q;
   assign out_idx    = rd_cnt_q;
   assign out_re     = res_re_q[rd_cnt_q];
   assign out_im     = res_im_q[rd_cnt_q];
   assign out_last   = out_valid_q && (rd_cnt_q == 3'd7);

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Testbench for fft8_frame_ctrl.
// A behavioural datapath (ideal 8-point DFT with pipeline delay) is attached
// to fft_x/fft_yr/fft_yi. Stimulus pushes expected bins into a scoreboard
// queue, and a negedge monitor pops and compares whenever a bin handshakes.
module tb_fft8_frame_ctrl;

   localparam int W        = 16;
   localparam int PIPE_LAT = 3;
   localparam int DP_DEPTH = PIPE_LAT - 1;

   typedef logic signed [W-1:0] vec8_t [8];
   typedef struct {
      logic [W-1:0] re;
      logic [W-1:0] im;
      logic [2:0]   idx;
      logic         last;
   } bin_t;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           in_valid = 1'b0;
   logic [W-1:0]   in_data = '0;
   logic           out_ready = 1'b0;
   logic           in_ready;
   logic [8*W-1:0] fft_x;
   logic           fft_launch;
   logic [8*W-1:0] fft_yr;
   logic [8*W-1:0] fft_yi;
   logic           out_valid;
   logic [W-1:0]   out_re;
   logic [W-1:0]   out_im;
   logic [2:0]     out_idx;
   logic           out_last;
   logic           busy;
   logic [7:0]     frame_cnt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int throttle_pct = 0;

   // Natural sample index n lands in this slot of the frame buffer.
   int slot_of [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   fft8_frame_ctrl #(.W(W), .PIPE_LAT(PIPE_LAT)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .fft_x(fft_x), .fft_launch(fft_launch),
      .fft_yr(fft_yr), .fft_yi(fft_yi),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_last(out_last),
      .busy(busy), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int rnd(input real v);
      return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
   endfunction

   // Ideal DFT: X[k] = sum x[n] * exp(-j*2*pi*n*k/8), rounded to an integer.
   function automatic void dft8(input vec8_t x, output vec8_t re, output vec8_t im);
      real ang, sr, si;
      int  t;
      for (int k = 0; k < 8; k++) begin
         sr = 0.0;
         si = 0.0;
         for (int n = 0; n < 8; n++) begin
            ang = 2.0 * 3.14159265358979 * real'(n * k) / 8.0;
            sr  = sr + real'(x[n]) * $cos(ang);
            si  = si - real'(x[n]) * $sin(ang);
         end
         t = rnd(sr);
         re[k] = t[W-1:0];
         t = rnd(si);
         im[k] = t[W-1:0];
      end
   endfunction

   task automatic checkOutput(input string name, input logic [8*W-1:0] act, input logic [8*W-1:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // Datapath model.
   // It un-bit-reverses the bus, applies the ideal DFT, and delays the result
   // through DP_DEPTH registers. The output is therefore settled before the
   // capture edge at the end of WAIT.
   vec8_t pipe_re [DP_DEPTH];
   vec8_t pipe_im [DP_DEPTH];

   always @(posedge clk) begin : datapath
      vec8_t xn, r, i;
      for (int n = 0; n < 8; n++) xn[n] = fft_x[slot_of[n]*W +: W];
      dft8(xn, r, i);
      pipe_re[0] <= r;
      pipe_im[0] <= i;
      for (int s = 1; s < DP_DEPTH; s++) begin
         pipe_re[s] <= pipe_re[s-1];
         pipe_im[s] <= pipe_im[s-1];
      end
   end

   always_comb begin
      fft_yr = '0;
      fft_yi = '0;
      for (int k = 0; k < 8; k++) begin
         fft_yr[k*W +: W] = pipe_re[DP_DEPTH-1][k];
         fft_yi[k*W +: W] = pipe_im[DP_DEPTH-1][k];
      end
   end

   // Downstream backpressure.
   always @(posedge clk) begin
      #1;
      out_ready = ($urandom_range(99) >= throttle_pct);
   end

   // Reference model and scoreboard state. Only the monitor writes these.
   logic [W-1:0] samples [$];
   bin_t         sb [$];
   logic [W-1:0] frame_snap [8];
   logic [7:0]   m_frame_cnt = '0;
   bit           m_busy = 0;
   bit           set_pend = 0;
   bit           clr_pend = 0;
   int           last8_cyc = -100;
   int           rst_cycles = 0;
   bit           hold_pend = 0;
   logic [W-1:0] hold_re, hold_im;
   logic [2:0]   hold_idx;

   // Monitor.
   // Runs on the negedge. A handshake seen here completes on the next posedge,
   // and its effect on busy/in_ready shows up at the negedge after that.
   always @(negedge clk) begin : monitor
      vec8_t x, r, i;
      bin_t  b;
      if (!rst) begin
         samples.delete();
         sb.delete();
         m_frame_cnt = '0;
         m_busy      = 0;
         set_pend    = 0;
         clr_pend    = 0;
         last8_cyc   = -100;
         rst_cycles  = 0;
         hold_pend   = 0;
      end else begin
         rst_cycles++;
         if (set_pend) m_busy = 1;
         if (clr_pend) m_busy = 0;
         set_pend = 0;
         clr_pend = 0;

         checkOutput("frame_cnt", frame_cnt, m_frame_cnt);
         checkOutput("busy", busy, m_busy);
         if (m_busy) checkOutput("in_ready_busy", in_ready, 1'b0);
         else if (rst_cycles > 1) checkOutput("in_ready_idle", in_ready, 1'b1);
         checkOutput("fft_launch", fft_launch, (cyc == last8_cyc + 1));
         checkOutput("out_valid", out_valid, m_busy && (cyc >= last8_cyc + 1 + PIPE_LAT));
         if (fft_launch) begin
            for (int n = 0; n < 8; n++)
               checkOutput("fft_x_slot", fft_x[slot_of[n]*W +: W], frame_snap[n]);
         end

         if (hold_pend) begin
            checkOutput("hold_re", out_re, hold_re);
            checkOutput("hold_im", out_im, hold_im);
            checkOutput("hold_idx", out_idx, hold_idx);
         end
         hold_pend = 0;
         if (out_valid && !out_ready) begin
            hold_pend = 1;
            hold_re   = out_re;
            hold_im   = out_im;
            hold_idx  = out_idx;
         end

         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_bin: got bin idx %0d, expected no output", out_idx);
            end else begin
               b = sb.pop_front();
               checkOutput("out_re", out_re, b.re);
               checkOutput("out_im", out_im, b.im);
               checkOutput("out_idx", out_idx, b.idx);
               checkOutput("out_last", out_last, b.last);
               if (b.last) begin
                  clr_pend = 1;
                  m_frame_cnt++;
               end
            end
         end

         if (in_valid && in_ready) begin
            samples.push_back(in_data);
            if (samples.size() == 8) begin
               for (int n = 0; n < 8; n++) begin
                  x[n]          = samples[n];
                  frame_snap[n] = samples[n];
               end
               dft8(x, r, i);
               for (int k = 0; k < 8; k++) begin
                  b.re   = r[k];
                  b.im   = i[k];
                  b.idx  = 3'(k);
                  b.last = (k == 7);
                  sb.push_back(b);
               end
               samples.delete();
               set_pend  = 1;
               last8_cyc = cyc;
            end
         end
      end
   end

   task automatic checkResetValues();
      checkOutput("rst_in_ready", in_ready, 1'b0);
      checkOutput("rst_out_valid", out_valid, 1'b0);
      checkOutput("rst_fft_launch", fft_launch, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_frame_cnt", frame_cnt, 8'd0);
      checkOutput("rst_fft_x", fft_x, '0);
      checkOutput("rst_out_re", out_re, '0);
      checkOutput("rst_out_im", out_im, '0);
      checkOutput("rst_out_idx", out_idx, 3'd0);
      checkOutput("rst_out_last", out_last, 1'b0);
   endtask

   // Asserts reset immediately and checks that outputs clear.
   // Returns aligned to posedge+1 with reset released.
   task automatic pulseReset();
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      checkResetValues();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Called at posedge+1. Returns at posedge+1 right after the accepting edge,
   // with in_valid still high.
   task automatic sendSample(input logic [W-1:0] d, input int gap_pct);
      int waited;
      waited = 0;
      if ($urandom_range(99) < gap_pct) begin
         in_valid = 1'b0;
         repeat ($urandom_range(3, 1)) @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = d;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            break;
         end
         waited++;
         if (waited > 500) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: sample %0h still waiting after %0d cycles, expected acceptance", d, waited);
            in_valid = 1'b0;
            break;
         end
      end
   endtask

   // mode 0: all ones, 1: ramp 1..8, 2: random signed samples.
   task automatic applyStimulus(input int mode, input int n_frames, input int gap_pct);
      logic [W-1:0] d;
      for (int f = 0; f < n_frames; f++) begin
         for (int n = 0; n < 8; n++) begin
            case (mode)
               0:       d = W'(1);
               1:       d = W'(n + 1);
               default: d = W'($urandom_range(4000)) - W'(2000);
            endcase
            sendSample(d, gap_pct);
         end
      end
   endtask

   task automatic waitIdle(input int limit);
      int n;
      n = 0;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() == 0 && samples.size() == 0 && !m_busy && !set_pend && !clr_pend) break;
         n++;
         if (n > limit) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: %0d bins pending after %0d cycles, expected 0", sb.size(), n);
            break;
         end
      end
   endtask

   initial begin : stimulus
      logic [8*W-1:0] ramp_x;
      int n;
      ramp_x = {16'd8, 16'd4, 16'd6, 16'd2, 16'd7, 16'd3, 16'd5, 16'd1};

      #2;
      checkResetValues();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // 1: all-ones frame, no backpressure.
      $display("[TB] test 1: constant frame");
      throttle_pct = 0;
      applyStimulus(0, 1, 0);
      in_valid = 1'b0;
      checkOutput("t1_launch", fft_launch, 1'b1);
      waitIdle(200);
      checkOutput("t1_frame_cnt", frame_cnt, 8'd1);

      // 2: ramp frame and its slot placement.
      $display("[TB] test 2: ramp frame");
      applyStimulus(1, 1, 0);
      in_valid = 1'b0;
      checkOutput("t2_launch", fft_launch, 1'b1);
      checkOutput("t2_fft_x", fft_x, ramp_x);
      waitIdle(200);
      checkOutput("t2_frame_cnt", frame_cnt, 8'd2);

      // 3: random gaps and downstream throttling.
      $display("[TB] test 3: random gaps and backpressure");
      throttle_pct = 30;
      applyStimulus(2, 8, 50);
      in_valid = 1'b0;
      waitIdle(500);
      throttle_pct = 0;

      // 4: reset mid-FILL, then reset mid-DRAIN at bin 3.
      $display("[TB] test 4: aborted frames");
      for (int k = 0; k < 5; k++) sendSample(W'($urandom_range(500)), 0);
      pulseReset();
      applyStimulus(2, 1, 0);
      in_valid = 1'b0;
      waitIdle(200);
      checkOutput("t4_frame_cnt_a", frame_cnt, 8'd1);
      applyStimulus(2, 1, 0);
      in_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(out_valid && out_idx == 3'd3) && n < 200);
      if (n >= 200) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: bin 3 not seen after %0d cycles, expected out_idx 3", n);
      end
      #1;
      pulseReset();
      applyStimulus(2, 1, 0);
      in_valid = 1'b0;
      waitIdle(200);
      checkOutput("t4_frame_cnt_b", frame_cnt, 8'd1);

      // 5: in_valid held high continuously for 256 frames, checking wrap.
      $display("[TB] test 5: 256 back-to-back frames");
      pulseReset();
      applyStimulus(2, 256, 0);
      in_valid = 1'b0;
      waitIdle(200);
      checkOutput("t5_frame_cnt_wrap", frame_cnt, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
